// File: rtl/addr_lut_pkg.sv
// Shared defaults and the identity-map helper for the banked address lookup table.
// The helper gives both the reset contents and a reference for checking.
package addr_lut_pkg;

  localparam int D_DEF     = 8;
  localparam int IW_DEF    = 3;
  localparam int BANKS_DEF = 4;

  // Identity entry: bank * 2^iw + idx. Callers truncate to the entry width.
  function automatic int ident_addr(input int bank, input int idx, input int iw);
    return (bank << iw) + idx;
  endfunction

endpackage

// File: rtl/lut_bank_ptr.sv
// Wrapping bank pointer: clear beats increment beats hold.
// wrap pulses for one cycle after an increment rolls the pointer over to 0.
module lut_bank_ptr #(
  parameter int BW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [BW-1:0] ptr,
  output logic          wrap
);

  logic [BW-1:0] ptr_q, ptr_d;
  logic          wrap_q, wrap_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ptr_d  = ptr_q;
    wrap_d = 1'b0;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d  = ptr_q + 1'b1;
      wrap_d = (ptr_q == '1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      wrap_q <= wrap_d;
    end
  end

  assign ptr  = ptr_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/addr_lut_banked.sv
// Programmable banked address lookup for lw/sw: maps (bank pointer, index) to a
// data-memory address with one cycle of latency and write-through on collision.
module addr_lut_banked
  import addr_lut_pkg::*;
#(
  parameter int D     = D_DEF,
  parameter int IW    = IW_DEF,
  parameter int BANKS = BANKS_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      lk_valid,
  input  logic [IW-1:0]             lk_idx,
  input  logic                      ina,
  input  logic                      bank_clr,
  input  logic                      wr_en,
  input  logic [$clog2(BANKS)-1:0]  wr_bank,
  input  logic [IW-1:0]             wr_idx,
  input  logic [D-1:0]              wr_data,
  output logic [D-1:0]              mem_addr,
  output logic                      addr_valid,
  output logic [$clog2(BANKS)-1:0]  bank,
  output logic                      bank_wrap
);

  localparam int BW      = $clog2(BANKS);
  localparam int ENTRIES = 1 << IW;

  logic [D-1:0] lut_q [BANKS][ENTRIES];
  logic [D-1:0] lut_d [BANKS][ENTRIES];
  logic [D-1:0] mem_addr_q, mem_addr_d;
  logic         addr_valid_q, addr_valid_d;
  logic [D-1:0] rd_data;
  logic [BW-1:0] bank_ptr;

  lut_bank_ptr #(.BW(BW)) u_bank_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bank_clr),
    .inc   (ina),
    .ptr   (bank_ptr),
    .wrap  (bank_wrap)
  );

  always_comb begin
    lut_d = lut_q;
    if (wr_en) lut_d[wr_bank][wr_idx] = wr_data;
  end

  // Lookup uses the pre-update pointer; a same-entry write is forwarded.
  always_comb begin
    rd_data = lut_q[bank_ptr][lk_idx];
    if (wr_en && (wr_bank == bank_ptr) && (wr_idx == lk_idx)) rd_data = wr_data;
    mem_addr_d   = lk_valid ? rd_data : mem_addr_q;
    addr_valid_d = lk_valid;
  end

  // NOTE: the table is reset to the identity map, so it is plain flops and must
  // never be mapped to a RAM macro, which could not honour this reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < BANKS; b++) begin
        for (int i = 0; i < ENTRIES; i++) begin
          lut_q[b][i] <= D'(ident_addr(b, i, IW));
        end
      end
      mem_addr_q   <= '0;
      addr_valid_q <= 1'b0;
    end else begin
      lut_q        <= lut_d;
      mem_addr_q   <= mem_addr_d;
      addr_valid_q <= addr_valid_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign addr_valid = addr_valid_q;
  assign bank       = bank_ptr;

endmodule

// File: doc/addr_lut_banked.md
Name: addr_lut_banked

Overview:
- Programmable, banked address lookup table for lw/sw address generation.
- Maps a short instruction index field plus an internal bank pointer to a D-bit data-memory address.
- The bank pointer advances when an INA instruction executes.
- Sits between the decoder/control unit and the data memory address port.
- Entries are runtime-writable and reset to the identity map (bank*2^IW + idx). Post-reset behaviour therefore equals the fixed 4x8 table of the previous generation.

Parameters:
D, 8, data-memory address width (output width and entry width)
IW, 3, index field width; 2^IW entries per bank
BANKS, 4, number of banks; power of two, >= 2
BW, $clog2(BANKS), bank pointer width (derived, not overridable)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
lk_valid  in  1  lookup request this cycle
lk_idx  in  IW  index from the lw/sw instruction low bits
ina  in  1  INA executed: advance the bank pointer
bank_clr  in  1  force the bank pointer to 0
wr_en  in  1  write one table entry
wr_bank  in  BW  bank of the entry being written
wr_idx  in  IW  index of the entry being written
wr_data  in  D  new entry value
mem_addr  out  D  registered looked-up address
addr_valid  out  1  mem_addr updated from a lookup this cycle
bank  out  BW  current bank pointer
bank_wrap  out  1  one-cycle pulse when the pointer wraps BANKS-1 -> 0

Behaviour:
- Reset (async assert, sync-safe release):
  - bank=0, mem_addr=0, addr_valid=0, bank_wrap=0.
  - table[b][i] = b*2^IW + i, truncated to D bits.
- Lookup latency is 1 cycle:
  - lk_valid at edge N registers table[bank][lk_idx] into mem_addr.
  - addr_valid=1 during cycle N+1.
  - With no lookup, mem_addr holds its last value and addr_valid=0.
- Bank pointer update:
  - Priority: bank_clr > ina > hold.
  - ina: bank <= bank+1 modulo BANKS.
  - bank_wrap pulses in the cycle after a BANKS-1 -> 0 transition caused by ina only; bank_clr never pulses it.
- Simultaneous lookup with ina or bank_clr: the lookup uses the pre-update bank. The new bank applies from the next lookup.
- Write: table[wr_bank][wr_idx] <= wr_data at the edge.
- Write and lookup to the same entry in the same cycle: write-through bypass, so mem_addr receives wr_data.
- Write and lookup to different entries: independent.
- Storage and arithmetic:
  - Table is flip-flop storage, BANKS*2^IW*D bits.
  - No synthesis-inferred RAM: reset init is required.
  - Bank increment is modulo 2^BW, which equals BANKS.
- X-safety: all case/mux selects have defined defaults. An out-of-range index is impossible by width.
- Reset asserted mid-operation: all state, including table contents, returns to reset values immediately. A lookup in flight is lost and addr_valid drops to 0.

Decomposition:
- Shared package addr_lut_pkg:
  - defaults D_DEF=8, IW_DEF=3, BANKS_DEF=4.
  - function ident_addr(bank, idx) for reset init and bench reference.
- One natural sub-module, lut_bank_ptr:
  - BW-bit wrapping counter with clr/inc priority and wrap pulse.
  - Reused by later multi-pointer variants.
- Table storage and read mux stay in the top module.

Test Plan:
- Reset then lookup:
  - rst_n low then high; lk_valid=1, lk_idx=5 -> next cycle mem_addr=5, addr_valid=1, bank=0.
  - Hold lk_valid=0 -> mem_addr stays 5, addr_valid=0.
- INA sweep and wrap:
  - 4x ina with a lookup lk_idx=2 after each -> mem_addr 10, 18, 26, 2.
  - bank_wrap pulses exactly once, after the 4th ina.
  - bank_clr with ina in the same cycle -> bank=0, no wrap pulse.
- Same-cycle ina and lookup:
  - bank=1, lk_idx=7, ina=1 -> mem_addr=15 (old bank).
  - Following lookup lk_idx=7 -> 23.
- Programming:
  - Write bank2 idx1 = 8'hA5; later lookup with bank=2, lk_idx=1 -> 8'hA5.
  - bank2 idx0 still 16.
- Write/lookup collision:
  - Same cycle wr_en to bank0 idx3 = 8'h3C and lookup bank0 idx3 -> mem_addr=8'h3C.
- Reset mid-operation:
  - After the writes above and bank=3, pulse rst_n low mid-cycle -> outputs 0 immediately, bank=0.
  - Lookup bank2 idx1 after release -> 17 (identity restored).
- Parameter sweep: rerun identity and wrap checks with D=10, IW=4, BANKS=8 -> bank 7 idx 15 maps to 127, and the pointer wraps after 8 ina.
